// File: rtl/disaster_pkg.sv
// Shared types and helpers for the disaster alarm controller.
package disaster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_ALARM  = 2'd2,
        ST_ACKED  = 2'd3
    } ch_state_t;

    localparam int unsigned CH_FLOOD   = 0;
    localparam int unsigned CH_CYCLONE = 1;
    localparam int unsigned CH_QUAKE   = 2;
    localparam int unsigned CH_TSUNAMI = 3;

    // Number of set bits; callers zero-extend narrower vectors to 32 bits.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/disaster_ch_filter.sv
// One hazard channel: persistence filter, latched alarm, acknowledge and clear hold.
module disaster_ch_filter
    import disaster_pkg::*;
#(
    parameter int unsigned PERSIST  = 8,
    parameter int unsigned CLR_HOLD = 16,
    parameter int unsigned CW       = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      haz,
    input  logic      ack,
    // Next-state view, so the top level registers its outputs on the same edge.
    output ch_state_t state,
    output logic      active,
    output logic      raise
);

    localparam logic [CW-1:0] P_LAST = CW'(PERSIST - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLR_HOLD - 1);

    ch_state_t     state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] ccnt_q, ccnt_d;

    // State and run-length counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            ccnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ccnt_q  <= ccnt_d;
        end
    end

    // Next-state logic; counters are cleared on every state exit.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        ccnt_d  = ccnt_q;
        raise   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (haz) begin
                    if (PERSIST == 1) begin
                        state_d = ST_ALARM;
                        raise   = 1'b1;
                    end else begin
                        state_d = ST_ARMING;
                        pcnt_d  = CW'(1);
                    end
                end
            end
            ST_ARMING: begin
                if (!haz) begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                end else if (pcnt_q == P_LAST) begin
                    state_d = ST_ALARM;
                    pcnt_d  = '0;
                    raise   = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_ALARM: begin
                if (ack) begin
                    if (haz) begin
                        state_d = ST_ACKED;
                        ccnt_d  = '0;
                    end else if (CLR_HOLD == 1) begin
                        // The acknowledging sample already satisfies the hold.
                        state_d = ST_IDLE;
                        ccnt_d  = '0;
                    end else begin
                        state_d = ST_ACKED;
                        ccnt_d  = CW'(1);
                    end
                end
            end
            ST_ACKED: begin
                if (haz) begin
                    ccnt_d = '0;
                end else if (ccnt_q == C_LAST) begin
                    state_d = ST_IDLE;
                    ccnt_d  = '0;
                end else begin
                    ccnt_d = ccnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pcnt_d  = '0;
                ccnt_d  = '0;
            end
        endcase
    end

    assign state  = state_d;
    assign active = (state_d == ST_ALARM) || (state_d == ST_ACKED);

endmodule

// File: rtl/disaster_alarm_ctrl.sv
// Multi-channel disaster alarm controller: per-channel filters, blink generator,
// priority select, LED mux and saturating event counter.
module disaster_alarm_ctrl
    import disaster_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned PERSIST    = 8,
    parameter int unsigned CLR_HOLD   = 16,
    parameter int unsigned BLINK_HALF = 25000000,
    parameter int unsigned EVT_W      = 8,
    localparam int unsigned IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  haz_in,
    input  logic [N_CH-1:0]  ack,
    input  logic             mode,
    output logic [N_CH-1:0]  led,
    output logic             alarm_any,
    output logic             top_valid,
    output logic [IDX_W-1:0] top_idx,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int unsigned CNT_MAX = (PERSIST > CLR_HOLD) ? PERSIST : CLR_HOLD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned SW      = EVT_W + $clog2(N_CH + 1);

    ch_state_t        st_nxt [N_CH];
    logic [N_CH-1:0]  act_nxt;
    logic [N_CH-1:0]  raise;

    logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic [N_CH-1:0]  led_q, led_d;
    logic             any_q, any_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [SW-1:0]    evt_sum;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        disaster_ch_filter #(
            .PERSIST  (PERSIST),
            .CLR_HOLD (CLR_HOLD),
            .CW       (CW)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .haz    (haz_in[g]),
            .ack    (ack[g]),
            .state  (st_nxt[g]),
            .active (act_nxt[g]),
            .raise  (raise[g])
        );
    end

    // Priority select: lowest active channel index wins.
    always_comb begin
        any_d = |act_nxt;
        idx_d = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (act_nxt[i]) idx_d = IDX_W'(i);
        end
    end

    // Blink generator restarts lit on the first alarmed cycle.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!any_d || !any_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // LED mux: steady when acknowledged, blinking while alarmed.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if ((st_nxt[i] == ST_ACKED) || ((st_nxt[i] == ST_ALARM) && phase_d)) begin
                led_d[i] = mode || (idx_d == IDX_W'(i));
            end
        end
    end

    // Event counter adds all raises this edge and saturates.
    always_comb begin
        evt_sum = SW'(evt_q) + SW'(popcount(32'(raise)));
        if (evt_sum > SW'({EVT_W{1'b1}})) begin
            evt_d = {EVT_W{1'b1}};
        end else begin
            evt_d = evt_sum[EVT_W-1:0];
        end
    end

    // Output and blink registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            led_q       <= '0;
            any_q       <= 1'b0;
            idx_q       <= '0;
            evt_q       <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            any_q       <= any_d;
            idx_q       <= idx_d;
            evt_q       <= evt_d;
        end
    end

    assign led       = led_q;
    assign alarm_any = any_q;
    assign top_valid = any_q;
    assign top_idx   = idx_q;
    assign evt_cnt   = evt_q;

endmodule

// File: tb/tb_disaster_alarm_ctrl.sv
// Bench for disaster_alarm_ctrl: directed stimulus, a behavioural model checked on
// every negedge, plus hand-computed literal expectations.
module tb_disaster_alarm_ctrl;

    localparam int N_CH       = 4;
    localparam int PERSIST    = 3;
    localparam int CLR_HOLD   = 4;
    localparam int BLINK_HALF = 2;
    localparam int EVT_W      = 2;
    localparam int EVT_MAX    = 3;

    // Model channel conditions.
    localparam int M_IDLE   = 0;
    localparam int M_ARMING = 1;
    localparam int M_ALARM  = 2;
    localparam int M_ACKED  = 3;

    logic             clk;
    logic             rst_n;
    logic [N_CH-1:0]  haz_in;
    logic [N_CH-1:0]  ack;
    logic             mode;
    logic [N_CH-1:0]  led;
    logic             alarm_any;
    logic             top_valid;
    logic [1:0]       top_idx;
    logic [EVT_W-1:0] evt_cnt;

    disaster_alarm_ctrl #(
        .N_CH       (N_CH),
        .PERSIST    (PERSIST),
        .CLR_HOLD   (CLR_HOLD),
        .BLINK_HALF (BLINK_HALF),
        .EVT_W      (EVT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .haz_in    (haz_in),
        .ack       (ack),
        .mode      (mode),
        .led       (led),
        .alarm_any (alarm_any),
        .top_valid (top_valid),
        .top_idx   (top_idx),
        .evt_cnt   (evt_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: condition, consecutive-high and consecutive-low run lengths.
    int         m_st [N_CH];
    int         m_hi [N_CH];
    int         m_lo [N_CH];
    int         m_k;           // cycles since alarm_any rose
    bit         m_any_prev;
    logic [3:0] e_led;
    logic       e_any;
    logic [1:0] e_idx;
    logic [1:0] e_evt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_st[c] = M_IDLE;
            m_hi[c] = 0;
            m_lo[c] = 0;
        end
        m_k        = 0;
        m_any_prev = 0;
        e_led      = '0;
        e_any      = 1'b0;
        e_idx      = '0;
        e_evt      = '0;
    endtask

    task automatic model_step();
        int raises = 0;
        int low    = -1;
        int tot;
        bit any    = 0;
        bit ph;
        bit lit;
        for (int c = 0; c < N_CH; c++) begin
            case (m_st[c])
                M_IDLE: if (haz_in[c]) begin
                    m_hi[c] = 1;
                    if (m_hi[c] >= PERSIST) begin
                        m_st[c] = M_ALARM;
                        raises++;
                    end else m_st[c] = M_ARMING;
                end
                M_ARMING: if (haz_in[c]) begin
                    m_hi[c]++;
                    if (m_hi[c] >= PERSIST) begin
                        m_st[c] = M_ALARM;
                        raises++;
                    end
                end else m_st[c] = M_IDLE;
                M_ALARM: if (ack[c]) begin
                    m_lo[c] = haz_in[c] ? 0 : 1;
                    m_st[c] = (m_lo[c] >= CLR_HOLD) ? M_IDLE : M_ACKED;
                end
                default: begin
                    m_lo[c] = haz_in[c] ? 0 : m_lo[c] + 1;
                    if (m_lo[c] >= CLR_HOLD) m_st[c] = M_IDLE;
                end
            endcase
            if (m_st[c] == M_ALARM || m_st[c] == M_ACKED) begin
                any = 1;
                if (low < 0) low = c;
            end
        end
        m_k        = (any && m_any_prev) ? m_k + 1 : 0;
        m_any_prev = any;
        ph         = ((m_k / BLINK_HALF) % 2) == 0;
        e_led      = '0;
        for (int c = 0; c < N_CH; c++) begin
            lit = (m_st[c] == M_ACKED) || (m_st[c] == M_ALARM && ph);
            if (lit && (mode || c == low)) e_led[c] = 1'b1;
        end
        e_any = any;
        e_idx = any ? 2'(low) : 2'd0;
        tot   = int'(e_evt) + raises;
        e_evt = (tot > EVT_MAX) ? 2'(EVT_MAX) : 2'(tot);
    endtask

    // Model advances on every clock edge and resets asynchronously with the DUT.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare all outputs against the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("led", 32'(led), 32'(e_led));
            check("alarm_any", 32'(alarm_any), 32'(e_any));
            check("top_valid", 32'(top_valid), 32'(e_any));
            check("top_idx", 32'(top_idx), 32'(e_idx));
            check("evt_cnt", 32'(evt_cnt), 32'(e_evt));
        end
    end

    task automatic step(input logic [3:0] h, input logic [3:0] a, input logic m);
        haz_in = h;
        ack    = a;
        mode   = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b1;
        haz_in = '0;
        ack    = '0;
        mode   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_led", 32'(led), 32'h0);
        check("rst_evt", 32'(evt_cnt), 32'h0);
        rst_n = 1'b1;

        // Short pulse does not arm an alarm.
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check("short_led", 32'(led), 32'h0);
        check("short_any", 32'(alarm_any), 32'h0);

        // Held flood: alarm on third edge, then blink with half period 2.
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("arm2_any", 32'(alarm_any), 32'h0);
        step(4'b0001, 4'b0000, 1'b0);
        check("raise_led", 32'(led), 32'h1);
        check("raise_evt", 32'(evt_cnt), 32'h1);
        check("model_evt", 32'(e_evt), 32'h1);
        step(4'b0001, 4'b0000, 1'b0);
        check("blink_k1", 32'(led), 32'h1);
        step(4'b0001, 4'b0000, 1'b0);
        check("blink_k2", 32'(led), 32'h0);
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("blink_k4", 32'(led), 32'h1);

        // Ack with hazard low counts as the first clear sample.
        step(4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check("acked_led", 32'(led), 32'h1);
        step(4'b0000, 4'b0000, 1'b0);
        check("clr_led", 32'(led), 32'h0);
        check("clr_any", 32'(alarm_any), 32'h0);

        // Cyclone and tsunami together: priority mode then show-all.
        step(4'b1010, 4'b0000, 1'b0);
        step(4'b1010, 4'b0000, 1'b0);
        step(4'b1010, 4'b0000, 1'b0);
        check("pri_idx", 32'(top_idx), 32'h1);
        check("pri_led", 32'(led), 32'h2);
        check("pri_evt", 32'(evt_cnt), 32'h3);
        step(4'b1010, 4'b0000, 1'b1);
        check("all_led", 32'(led), 32'ha);
        step(4'b1010, 4'b0000, 1'b1);
        step(4'b1010, 4'b0000, 1'b1);
        step(4'b0000, 4'b1010, 1'b1);
        check("all_ack_led", 32'(led), 32'ha);
        step(4'b0000, 4'b0000, 1'b0);
        check("pri_ack_led", 32'(led), 32'h2);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);

        // Quake: latched through hazard drop, clear hold restarted by a high sample.
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        check("sat_evt", 32'(evt_cnt), 32'h3);
        step(4'b0000, 4'b0000, 1'b0);
        check("latch_any", 32'(alarm_any), 32'h1);
        check("latch_idx", 32'(top_idx), 32'h2);
        step(4'b0000, 4'b0100, 1'b0);
        check("steady_led", 32'(led), 32'h4);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check("hold3_led", 32'(led), 32'h4);
        check("hold3_any", 32'(alarm_any), 32'h1);
        step(4'b0000, 4'b0000, 1'b0);
        check("hold4_led", 32'(led), 32'h0);
        check("hold4_any", 32'(alarm_any), 32'h0);

        // Ack while arming is ignored.
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0001, 1'b0);
        check("armack_any", 32'(alarm_any), 32'h0);
        step(4'b0001, 4'b0000, 1'b0);
        check("armack_raise", 32'(led), 32'h1);
        step(4'b0011, 4'b0000, 1'b1);

        // Asynchronous reset mid-alarm, between edges.
        #1 rst_n = 1'b0;
        #1;
        check("async_led", 32'(led), 32'h0);
        check("async_evt", 32'(evt_cnt), 32'h0);
        check("async_any", 32'(alarm_any), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("rearm_any", 32'(alarm_any), 32'h0);
        step(4'b0001, 4'b0000, 1'b0);
        check("rearm_led", 32'(led), 32'h1);
        check("rearm_evt", 32'(evt_cnt), 32'h1);

        // A few mixed cycles for the per-cycle model compare.
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b0000, 1'b1);
        step(4'b1111, 4'b0001, 1'b0);
        step(4'b0110, 4'b0000, 1'b1);
        step(4'b0000, 4'b1111, 1'b1);
        repeat (6) step(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
